mem_stage: RTL and testbench

- Memory-access stage of the 5-stage 32-bit pipeline; sits between EX and WB.
- Performs word loads and stores on an internal data memory with fixed multi-cycle latency.
- Stalls upstream while an access is in flight.
- Owns the MEM/WB pipeline register that drives the WB stage's dadoLidoWB, resultadoALUWB, memToRegWB, RD and regWrite inputs.

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_stage_data_memory.sv | 32 +++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, FSM state and bundle types for the
// MEM stage (captured request and MEM/WB register).
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] alu;
        logic              mem_to_reg;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              valid;
    } wb_t;

    // EX/MEM request as seen by the stage (live or captured)
    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic [REG_W-1:0]  rd;
    } mem_req_t;

endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: single-port word array, synchronous write and
// synchronous read on the access edge; contents are never reset.
// Ports: clock, we/re strobes, word index idx, wdata in, rdata out.
module data_memory #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    import mem_stage_pkg::*;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB; multi-cycle word
// load/store on a private data memory, owns the MEM/WB register.
// Ports: clock/reset (sync, active-high); EX/MEM request *_in;
// stall_out holds upstream; dadoLidoWB/resultadoALUWB/memToRegWB/RD_WB/
// regWriteWB/valid_WB feed WB; err_out pulses on a faulty access.
module mem_stage #(
    parameter int DATA_W      = mem_stage_pkg::DATA_W,
    parameter int REG_W       = mem_stage_pkg::REG_W,
    parameter int MEM_DEPTH   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] resultadoALU_in,
    input  logic [DATA_W-1:0] dadoEscrita_in,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic              memToReg_in,
    input  logic              regWrite_in,
    input  logic [REG_W-1:0]  RD_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] dadoLidoWB,
    output logic [DATA_W-1:0] resultadoALUWB,
    output logic              memToRegWB,
    output logic [REG_W-1:0]  RD_WB,
    output logic              regWriteWB,
    output logic              valid_WB,
    output logic              err_out
);
    import mem_stage_pkg::*;

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam bit MULTI = (MEM_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 2);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    wb_t              wb_q, wb_d;
    logic             ld_ok_q, ld_ok_d;
    logic             err_q, err_d;

    mem_req_t          in_req;
    mem_req_t          cur;
    logic              busy;
    logic              mem_op_in;
    logic              complete;
    logic              load_wb;
    logic              misaligned;
    logic              rw_both;
    logic              fault;
    logic              mem_we;
    logic              mem_re;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr;

    assign in_req = '{
        alu:        resultadoALU_in,
        wdata:      dadoEscrita_in,
        mem_read:   memRead_in,
        mem_write:  memWrite_in,
        mem_to_reg: memToReg_in,
        reg_write:  regWrite_in,
        rd:         RD_in
    };

    assign busy      = (state_q == BUSY);
    assign mem_op_in = valid_in && (memRead_in || memWrite_in);

    // While BUSY the captured copy drives everything; upstream may change
    assign cur = busy ? req_q : in_req;

    // With single-cycle latency a memory op completes straight from IDLE
    assign complete = busy ? (cnt_q == '0) : (mem_op_in && !MULTI);
    assign load_wb  = busy ? (cnt_q == '0)
                           : (valid_in && !(mem_op_in && MULTI));

    assign misaligned = (cur.alu[1:0] != 2'b00);
    assign rw_both    = cur.mem_read && cur.mem_write;
    assign fault      = misaligned || rw_both;

    // read+write is treated as a store; reset on the commit edge aborts it
    assign mem_we = complete && cur.mem_write && !misaligned && !reset;
    assign mem_re = complete && cur.mem_read && !cur.mem_write
                    && !misaligned;

    // upper address bits are dropped so accesses wrap
    assign mem_idx     = cur.alu[IDX_W+1:2];
    assign unused_addr = ^cur.alu[DATA_W-1:IDX_W+2];

    assign stall_out = !reset
                       && (busy ? (cnt_q != '0) : (mem_op_in && MULTI));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        wb_d    = '0;
        ld_ok_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op_in && MULTI) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    req_d   = in_req;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_wb) begin
            wb_d.valid      = 1'b1;
            wb_d.alu        = cur.alu;
            wb_d.mem_to_reg = cur.mem_to_reg;
            wb_d.rd         = cur.rd;
            wb_d.reg_write  = cur.reg_write && !(complete && fault);
            err_d           = complete && fault;
            ld_ok_d         = mem_re;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            wb_q    <= '0;
            ld_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            wb_q    <= wb_d;
            ld_ok_q <= ld_ok_d;
            err_q   <= err_d;
        end
    end

    data_memory #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_dmem (
        .clock (clock),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (mem_idx),
        .wdata (cur.wdata),
        .rdata (mem_rdata)
    );

    // load data lives in the memory's read register, qualified here
    assign dadoLidoWB     = ld_ok_q ? mem_rdata : wb_q.data;
    assign resultadoALUWB = wb_q.alu;
    assign memToRegWB     = wb_q.mem_to_reg;
    assign RD_WB          = wb_q.rd;
    assign regWriteWB     = wb_q.reg_write;
    assign valid_WB       = wb_q.valid;
    assign err_out        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a
// word-array reference model of the stage's load/store rules.
module tb_mem_stage;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [31:0] dado;
        logic [31:0] alu;
        logic        m2r;
        logic [4:0]  rd;
        logic        rw;
        logic        valid;
        logic        err;
    } obs_t;

    logic        clock;
    logic        reset;
    logic        valid_in;
    logic [31:0] resultadoALU_in;
    logic [31:0] dadoEscrita_in;
    logic        memRead_in;
    logic        memWrite_in;
    logic        memToReg_in;
    logic        regWrite_in;
    logic [4:0]  RD_in;
    logic        stall_out;
    logic [31:0] dadoLidoWB;
    logic [31:0] resultadoALUWB;
    logic        memToRegWB;
    logic [4:0]  RD_WB;
    logic        regWriteWB;
    logic        valid_WB;
    logic        err_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [DEPTH];

    mem_stage #(
        .MEM_DEPTH   (DEPTH),
        .MEM_LATENCY (LAT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .valid_in        (valid_in),
        .resultadoALU_in (resultadoALU_in),
        .dadoEscrita_in  (dadoEscrita_in),
        .memRead_in      (memRead_in),
        .memWrite_in     (memWrite_in),
        .memToReg_in     (memToReg_in),
        .regWrite_in     (regWrite_in),
        .RD_in           (RD_in),
        .stall_out       (stall_out),
        .dadoLidoWB      (dadoLidoWB),
        .resultadoALUWB  (resultadoALUWB),
        .memToRegWB      (memToRegWB),
        .RD_WB           (RD_WB),
        .regWriteWB      (regWriteWB),
        .valid_WB        (valid_WB),
        .err_out         (err_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: what WB must show for one instruction, from the rules
    function automatic obs_t model(input logic v, input logic r,
                                   input logic w, input logic m2r,
                                   input logic rw, input logic [4:0] rdi,
                                   input logic [31:0] a,
                                   input logic [31:0] wd);
        obs_t e;
        int   word;
        bit   aligned;
        bit   bad;
        e = '0;
        if (!v) return e;
        e.valid = 1'b1;
        e.alu   = a;
        e.m2r   = m2r;
        e.rd    = rdi;
        if (!(r || w)) begin
            e.rw = rw;
            return e;
        end
        word    = int'((a / 4) % DEPTH);
        aligned = (a % 4 == 0);
        bad     = !aligned || (r && w);
        if (w && aligned) ref_mem[word] = wd;
        if (r && !w && aligned) e.dado = ref_mem[word];
        e.rw  = rw && !bad;
        e.err = bad;
        return e;
    endfunction

    function automatic int exp_stall(input logic v, input logic r,
                                     input logic w);
        return (v && (r || w)) ? LAT - 1 : 0;
    endfunction

    task automatic idle();
        valid_in        = 1'b0;
        resultadoALU_in = '0;
        dadoEscrita_in  = '0;
        memRead_in      = 1'b0;
        memWrite_in     = 1'b0;
        memToReg_in     = 1'b0;
        regWrite_in     = 1'b0;
        RD_in           = '0;
    endtask

    task automatic scramble();
        valid_in        = 1'($urandom_range(0, 1));
        resultadoALU_in = $urandom;
        dadoEscrita_in  = $urandom;
        memRead_in      = 1'($urandom_range(0, 1));
        memWrite_in     = 1'($urandom_range(0, 1));
        memToReg_in     = 1'($urandom_range(0, 1));
        regWrite_in     = 1'($urandom_range(0, 1));
        RD_in           = 5'($urandom);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.dado  = dadoLidoWB;
        o.alu   = resultadoALUWB;
        o.m2r   = memToRegWB;
        o.rd    = RD_WB;
        o.rw    = regWriteWB;
        o.valid = valid_WB;
        o.err   = err_out;
        return o;
    endfunction

    // Drives one instruction (called at posedge+1), holds it through the
    // stall while garbage shows on the inputs, returns WB after completion
    task automatic run_op(input logic v, input logic r, input logic w,
                          input logic m2r, input logic rw,
                          input logic [4:0] rdi, input logic [31:0] a,
                          input logic [31:0] wd,
                          output int st, output int bub, output obs_t o);
        valid_in        = v;
        memRead_in      = r;
        memWrite_in     = w;
        memToReg_in     = m2r;
        regWrite_in     = rw;
        RD_in           = rdi;
        resultadoALU_in = a;
        dadoEscrita_in  = wd;
        #1;
        st  = 0;
        bub = 0;
        while (stall_out && st < 16) begin
            st++;
            @(posedge clock);
            #1;
            if (valid_WB || regWriteWB || err_out || dadoLidoWB != 0)
                bub++;
            scramble();
            #1;
        end
        @(posedge clock);
        #1;
        o = sample();
        idle();
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1;
        valid_in = 1'b1;
        memRead_in = 1'b1;
        resultadoALU_in = 32'h40;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall: got %b want 0", stall_out);
        end
        @(posedge clock);
        #1;
        idle();
        o = sample();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_wb: got %h want 0", o);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu_op();
        obs_t o, e;
        int st, bub;
        e = model(1, 0, 0, 0, 1, 5'd5, 32'h10, 0);
        run_op(1, 0, 0, 0, 1, 5'd5, 32'h10, 0, st, bub, o);
        n_cmp++;
        if (o !== e || st != 0) begin
            n_bad++;
            $display("FAIL alu_r5: got %h st=%0d want %h st=0", o, st, e);
        end
        for (int i = 0; i < 8; i++) begin
            logic v, m2r, rw;
            logic [4:0] rdi;
            logic [31:0] a;
            v   = 1'(i % 3 != 0);
            m2r = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            rdi = 5'($urandom);
            a   = $urandom;
            e = model(v, 0, 0, m2r, rw, rdi, a, 0);
            run_op(v, 0, 0, m2r, rw, rdi, a, $urandom, st, bub, o);
            n_cmp++;
            if (o !== e || st != 0) begin
                n_bad++;
                $display("FAIL alu_rand %0d: got %h st=%0d want %h",
                         i, o, st, e);
            end
        end
    endtask

    task automatic test_store_load();
        obs_t o, e;
        int st, bub;
        e = model(1, 0, 1, 0, 0, 0, 32'h40, 32'hDEADBEEF);
        run_op(1, 0, 1, 0, 0, 0, 32'h40, 32'hDEADBEEF, st, bub, o);
        n_cmp++;
        if (o !== e || st != 1 || bub != 0) begin
            n_bad++;
            $display("FAIL store_40: got %h st=%0d bub=%0d want %h st=1",
                     o, st, bub, e);
        end
        e = model(1, 1, 0, 1, 1, 5'd7, 32'h40, 0);
        run_op(1, 1, 0, 1, 1, 5'd7, 32'h40, 0, st, bub, o);
        n_cmp++;
        if (o !== e || st != 1 || bub != 0) begin
            n_bad++;
            $display("FAIL load_40: got %h st=%0d bub=%0d want %h st=1",
                     o, st, bub, e);
        end
        n_cmp++;
        if (o.dado !== 32'hDEADBEEF || o.rd !== 5'd7 || o.m2r !== 1'b1)
        begin
            n_bad++;
            $display("FAIL load_40_val: got %h rd=%0d m2r=%b want deadbeef",
                     o.dado, o.rd, o.m2r);
        end
    endtask

    task automatic test_misaligned();
        obs_t o, e;
        int st, bub;
        e = model(1, 1, 0, 1, 1, 5'd3, 32'h402, 0);
        run_op(1, 1, 0, 1, 1, 5'd3, 32'h402, 0, st, bub, o);
        n_cmp++;
        if (o !== e || st != 1) begin
            n_bad++;
            $display("FAIL misalign: got %h st=%0d want %h", o, st, e);
        end
        n_cmp++;
        if (o.err !== 1'b1 || o.rw !== 1'b0 || o.dado !== '0) begin
            n_bad++;
            $display("FAIL misalign_err: got err=%b rw=%b d=%h want 1 0 0",
                     o.err, o.rw, o.dado);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (err_out !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse: got %b want 0", err_out);
        end
    endtask

    task automatic test_wrap();
        obs_t o, e;
        int st, bub;
        e = model(1, 0, 1, 0, 0, 0, 32'h404, 32'h1234);
        run_op(1, 0, 1, 0, 0, 0, 32'h404, 32'h1234, st, bub, o);
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL wrap_store: got %h want %h", o, e);
        end
        e = model(1, 1, 0, 1, 1, 5'd9, 32'h4, 0);
        run_op(1, 1, 0, 1, 1, 5'd9, 32'h4, 0, st, bub, o);
        n_cmp++;
        if (o !== e || o.dado !== 32'h1234) begin
            n_bad++;
            $display("FAIL wrap_load: got %h want %h", o, e);
        end
    endtask

    task automatic test_illegal();
        obs_t o, e;
        int st, bub;
        e = model(1, 1, 1, 0, 1, 5'd4, 32'h20, 32'h55);
        run_op(1, 1, 1, 0, 1, 5'd4, 32'h20, 32'h55, st, bub, o);
        n_cmp++;
        if (o !== e || o.err !== 1'b1 || o.rw !== 1'b0 || st != 1) begin
            n_bad++;
            $display("FAIL rw_both: got %h st=%0d want %h", o, st, e);
        end
        e = model(1, 1, 0, 1, 1, 5'd4, 32'h20, 0);
        run_op(1, 1, 0, 1, 1, 5'd4, 32'h20, 0, st, bub, o);
        n_cmp++;
        if (o !== e || o.dado !== 32'h55) begin
            n_bad++;
            $display("FAIL rw_both_load: got %h want %h", o, e);
        end
    endtask

    task automatic test_reset_abort();
        obs_t o, e;
        int st, bub;
        e = model(1, 0, 1, 0, 0, 0, 32'h80, 32'h13579BDF);
        run_op(1, 0, 1, 0, 0, 0, 32'h80, 32'h13579BDF, st, bub, o);
        valid_in        = 1'b1;
        memWrite_in     = 1'b1;
        resultadoALU_in = 32'h80;
        dadoEscrita_in  = 32'hAAAA;
        #1;
        n_cmp++;
        if (stall_out !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_accept: got stall %b want 1", stall_out);
        end
        @(posedge clock);
        #1;
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        o = sample();
        n_cmp++;
        if (o !== '0 || stall_out !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_out: got %h stall=%b want 0", o, stall_out);
        end
        reset = 1'b0;
        e = model(1, 1, 0, 1, 1, 5'd2, 32'h80, 0);
        run_op(1, 1, 0, 1, 1, 5'd2, 32'h80, 0, st, bub, o);
        n_cmp++;
        if (o !== e || o.dado !== 32'h13579BDF || st != 1) begin
            n_bad++;
            $display("FAIL abort_load: got %h st=%0d want %h", o, st, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int st, bub, kind, es;
        logic v, r, w, m2r, rw;
        logic [4:0] rdi;
        logic [31:0] a, wd;
        for (int k = 0; k < 16; k++) begin
            a  = 32'(k * 64 + 12);
            wd = $urandom;
            e = model(1, 0, 1, 0, 0, 0, a, wd);
            run_op(1, 0, 1, 0, 0, 0, a, wd, st, bub, o);
        end
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 5);
            v   = 1'b1;
            r   = 1'b0;
            w   = 1'b0;
            m2r = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            rdi = 5'($urandom);
            wd  = $urandom;
            a   = ($urandom & 32'hFFFF_FC00)
                  | 32'($urandom_range(0, 15) * 64 + 12);
            case (kind)
                0: begin
                    v = 1'b0;
                    r = 1'($urandom_range(0, 1));
                    w = 1'($urandom_range(0, 1));
                end
                1: a = $urandom;
                2: r = 1'b1;
                3: w = 1'b1;
                4: begin
                    r = 1'($urandom_range(0, 1));
                    w = !r;
                    a = a | 32'($urandom_range(1, 3));
                end
                default: begin
                    r = 1'b1;
                    w = 1'b1;
                end
            endcase
            es = exp_stall(v, r, w);
            e  = model(v, r, w, m2r, rw, rdi, a, wd);
            run_op(v, r, w, m2r, rw, rdi, a, wd, st, bub, o);
            n_cmp++;
            if (o !== e || st != es || bub != 0) begin
                n_bad++;
                $display("FAIL b2b %0d k=%0d: got %h st=%0d bub=%0d want %h st=%0d",
                         i, kind, o, st, bub, e, es);
            end
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_alu_op();
        test_store_load();
        test_misaligned();
        test_wrap();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
